// File: rtl/instr_fetch.sv
// Instruction fetch stage for the 8-bit single-cycle CPU.
// Holds the PC and a loadable instruction memory and hands the opcode to Control.
// A three-state run-control FSM covers program load (IDLE), execution (RUN)
// and self-loop halt detection (HALT).
module instr_fetch #(
  parameter int PC_W    = 4,
  parameter int INSTR_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               prog_we,
  input  logic [PC_W-1:0]    prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic               start,
  input  logic               branch_tkn,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] instr,
  output logic [1:0]         opcode,
  output logic               instr_vld,
  output logic               halted
);

  localparam int DEPTH = 2 ** PC_W;
  localparam logic [PC_W-1:0] PC_ZERO = {PC_W{1'b0}};
  localparam logic [PC_W-1:0] PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } state_t;

  state_t              state_r;
  logic [PC_W-1:0]     pc_r;
  logic                instr_vld_r;
  logic                halted_r;
  logic [INSTR_W-1:0]  mem_r [0:DEPTH-1];

  logic [INSTR_W-1:0]  instr_s;
  logic [PC_W-1:0]     pc_inc_s;
  logic [PC_W-1:0]     imm_ext_s;
  logic [PC_W-1:0]     pc_next_s;
  logic                self_loop_s;
  logic                mem_we_s;

  // Sign-extend the 2-bit branch offset to PC width.
  function automatic logic [PC_W-1:0] sext_imm(input logic [1:0] imm);
    sext_imm = {{(PC_W-2){imm[1]}}, imm};
  endfunction

  assign instr_s = mem_r[pc_r];

  // Next-PC selection: sequential increment or PC-relative branch target.
  always_comb begin
    pc_inc_s    = pc_r + PC_ONE;
    imm_ext_s   = sext_imm(instr_s[1:0]);
    pc_next_s   = pc_inc_s;
    self_loop_s = 1'b0;
    if (branch_tkn) begin
      pc_next_s   = pc_inc_s + imm_ext_s;
      self_loop_s = (instr_s[1:0] == 2'b11);
    end else begin
      pc_next_s   = pc_inc_s;
      self_loop_s = 1'b0;
    end
  end

  // Program loading is only honoured while idle and not in reset.
  always_comb begin
    mem_we_s = 1'b0;
    if ((state_r == IDLE) && !reset) begin
      mem_we_s = prog_we;
    end else begin
      mem_we_s = 1'b0;
    end
  end

  // Instruction memory write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[prog_addr] <= prog_data;
    end
  end

  // Run-control FSM with PC and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      pc_r        <= PC_ZERO;
      instr_vld_r <= 1'b0;
      halted_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          pc_r     <= PC_ZERO;
          halted_r <= 1'b0;
          // A load in the same cycle takes priority over start.
          if (start && !prog_we) begin
            state_r     <= RUN;
            instr_vld_r <= 1'b1;
          end else begin
            state_r     <= IDLE;
            instr_vld_r <= 1'b0;
          end
        end
        RUN: begin
          if (self_loop_s) begin
            // Branch back onto itself: freeze the PC and stop.
            state_r     <= HALT;
            instr_vld_r <= 1'b0;
            halted_r    <= 1'b1;
          end else begin
            state_r     <= RUN;
            pc_r        <= pc_next_s;
            instr_vld_r <= 1'b1;
            halted_r    <= 1'b0;
          end
        end
        HALT: begin
          state_r     <= HALT;
          instr_vld_r <= 1'b0;
          halted_r    <= 1'b1;
        end
        default: begin
          state_r     <= IDLE;
          pc_r        <= PC_ZERO;
          instr_vld_r <= 1'b0;
          halted_r    <= 1'b0;
        end
      endcase
    end
  end

  assign pc        = pc_r;
  assign instr     = instr_s;
  assign opcode    = instr_s[INSTR_W-1:INSTR_W-2];
  assign instr_vld = instr_vld_r;
  assign halted    = halted_r;

endmodule
